// File: rtl/vvbus_port_master.sv
// Bus master for the VV port bus: turns one request into a setup/strobe/hold bus cycle.
// Latency SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles to rsp_done; req_ready stays low while a bus cycle is in flight.
module vvbus_port_master #(
   parameter int unsigned SETUP_CYC  = 2,
   parameter int unsigned STROBE_CYC = 6,
   parameter int unsigned HOLD_CYC   = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic [7:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_done,
   output logic [7:0] rsp_rdata,
   output logic [7:0] shavv_n,
   output logic [7:0] data_o,
   output logic       data_oe,
   input  logic [7:0] data_i,
   output logic       zpvv_n,
   output logic       chtvv_n
);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
   localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
   localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       wr_q, wr_nxt;
   logic [7:0] addr_q, addr_nxt;
   logic [7:0] wdata_q, wdata_nxt;
   logic       accept;
   logic       last;
   logic       busy_nxt;

   assign req_ready = (state == IDLE) && !reset;
   assign accept    = req_valid && req_ready;
   assign last      = (cnt == 4'd0);
   assign busy_nxt  = (state_nxt != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         wr_q    <= 1'b0;
         addr_q  <= 8'h00;
         wdata_q <= 8'h00;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         wr_q    <= wr_nxt;
         addr_q  <= addr_nxt;
         wdata_q <= wdata_nxt;
      end
   end

   // Counter is loaded with (phase length - 1) on entry; the phase ends when it reaches zero.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      wr_nxt    = wr_q;
      addr_nxt  = addr_q;
      wdata_nxt = wdata_q;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = SETUP;
               cnt_nxt   = SETUP_LD;
               wr_nxt    = req_write;
               addr_nxt  = req_addr;
               wdata_nxt = req_wdata;
            end
         end
         SETUP: begin
            if (last) begin
               state_nxt = STROBE;
               cnt_nxt   = STROBE_LD;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         STROBE: begin
            if (last) begin
               state_nxt = HOLD;
               cnt_nxt   = HOLD_LD;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         HOLD: begin
            if (last) begin
               state_nxt = IDLE;
               cnt_nxt   = 4'd0;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   // Bus pins are flops fed from the next-state view so they line up with the state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         shavv_n   <= 8'hFF;
         data_o    <= 8'hFF;
         data_oe   <= 1'b0;
         zpvv_n    <= 1'b1;
         chtvv_n   <= 1'b1;
         rsp_done  <= 1'b0;
         rsp_rdata <= 8'hFF;
      end else begin
         shavv_n  <= busy_nxt ? ~addr_nxt : 8'hFF;
         data_oe  <= busy_nxt && wr_nxt;
         data_o   <= (busy_nxt && wr_nxt) ? wdata_nxt : 8'hFF;
         zpvv_n   <= !((state_nxt == STROBE) && wr_nxt);
         chtvv_n  <= !((state_nxt == STROBE) && !wr_nxt);
         rsp_done <= (state == HOLD) && last;
         if ((state == STROBE) && last && !wr_q) begin
            rsp_rdata <= data_i;
         end
      end
   end

endmodule

// File: tb/tb_vvbus_port_master.sv
// Randomized and directed bench for vvbus_port_master with a cycle-index reference model and response scoreboard.
module tb_vvbus_port_master;
   localparam int S = 2;
   localparam int T = 6;
   localparam int H = 2;
   localparam int N = S + T + H;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b1;
   logic       req_valid = 1'b0, req_ready, req_write = 1'b0;
   logic [7:0] req_addr = 8'h00, req_wdata = 8'h00;
   logic       rsp_done;
   logic [7:0] rsp_rdata, shavv_n, data_o;
   logic [7:0] data_i = 8'h00;
   logic       data_oe, zpvv_n, chtvv_n;

   logic       f_req_valid = 1'b0, f_req_ready, f_req_write = 1'b0;
   logic [7:0] f_req_addr = 8'h00, f_req_wdata = 8'h00;
   logic       f_rsp_done;
   logic [7:0] f_rsp_rdata, f_shavv_n, f_data_o;
   logic       f_data_oe, f_zpvv_n, f_chtvv_n;

   vvbus_port_master u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_done(rsp_done), .rsp_rdata(rsp_rdata), .shavv_n(shavv_n),
      .data_o(data_o), .data_oe(data_oe), .data_i(data_i),
      .zpvv_n(zpvv_n), .chtvv_n(chtvv_n)
   );

   vvbus_port_master #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) u_fast (
      .clk(clk), .reset(reset), .req_valid(f_req_valid), .req_ready(f_req_ready),
      .req_write(f_req_write), .req_addr(f_req_addr), .req_wdata(f_req_wdata),
      .rsp_done(f_rsp_done), .rsp_rdata(f_rsp_rdata), .shavv_n(f_shavv_n),
      .data_o(f_data_o), .data_oe(f_data_oe), .data_i(data_i),
      .zpvv_n(f_zpvv_n), .chtvv_n(f_chtvv_n)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int completions = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   bit         di_force = 1'b0;
   logic [7:0] di_val = 8'h00;
   initial forever begin
      @(posedge clk);
      #1;
      data_i = di_force ? di_val : 8'($urandom);
   end

   // Reference model: k is the cycle index since the accept edge (0 = no bus cycle).
   typedef struct {
      bit         wr;
      logic [7:0] rdata;
   } exp_t;
   exp_t       sb[$];
   int         k = 0;
   bit         m_wr = 1'b0;
   logic [7:0] m_addr = 8'h00, m_wdata = 8'h00, m_rdata = 8'hFF;
   bit         m_done = 1'b0;
   int         hi_run = 0, last_gap = -1;
   bit         seen_low = 1'b0;

   always @(negedge clk) begin : mon
      logic [7:0] e_sh, e_do;
      bit         strobe, busy;
      exp_t       e;
      if (cyc >= 1) begin
         busy   = (k != 0);
         strobe = (k > S) && (k <= S + T);
         e_sh   = busy ? ~m_addr : 8'hFF;
         e_do   = (busy && m_wr) ? m_wdata : 8'hFF;
         check("req_ready", req_ready, busy ? 1'b0 : !reset);
         check("shavv_n", shavv_n, e_sh);
         check("data_o", data_o, e_do);
         check("data_oe", data_oe, busy && m_wr);
         check("zpvv_n", zpvv_n, !(strobe && m_wr));
         check("chtvv_n", chtvv_n, !(strobe && !m_wr));
         check("rsp_done", rsp_done, m_done);
         check("rsp_rdata_hold", rsp_rdata, m_rdata);
         if (rsp_done) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_underflow cyc=%0d actual=rsp_done required=no_response", cyc);
            end else begin
               e = sb.pop_front();
               check("sb_rdata", rsp_rdata, e.rdata);
               completions++;
            end
         end
         if (reset) begin
            seen_low = 1'b0;
            hi_run   = 0;
         end else if (zpvv_n) begin
            hi_run++;
         end else begin
            if (seen_low && hi_run > 0) last_gap = hi_run;
            hi_run   = 0;
            seen_low = 1'b1;
         end
         if (reset) begin
            k       = 0;
            m_done  = 1'b0;
            m_rdata = 8'hFF;
         end else if (k == 0) begin
            m_done = 1'b0;
            if (req_valid) begin
               k       = 1;
               m_wr    = req_write;
               m_addr  = req_addr;
               m_wdata = req_wdata;
            end
         end else begin
            if (k == S + T && !m_wr) m_rdata = data_i;
            if (k == N) begin
               k      = 0;
               m_done = 1'b1;
               sb.push_back('{m_wr, m_rdata});
            end else begin
               k++;
               m_done = 1'b0;
            end
         end
      end
   end

   task automatic do_req(input bit wr, input logic [7:0] a, input logic [7:0] d,
                         input bit keep, output int waited);
      bit acc;
      acc    = 1'b0;
      waited = 0;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = d;
      for (int i = 0; i < 200 && !acc; i++) begin
         @(negedge clk);
         acc = req_ready;
         waited = i + 1;
         @(posedge clk);
         #1;
      end
      if (!acc) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout cyc=%0d actual=no_accept required=accept", cyc);
      end
      if (!keep) req_valid = 1'b0;
   endtask

   initial begin
      int w;
      @(posedge clk);
      #1;
      check("rst_ready", req_ready, 1'b0);
      check("rst_done", rsp_done, 1'b0);
      check("rst_rdata", rsp_rdata, 8'hFF);
      check("rst_shavv", shavv_n, 8'hFF);
      check("rst_data_o", data_o, 8'hFF);
      check("rst_oe", data_oe, 1'b0);
      check("rst_strobes", {zpvv_n, chtvv_n}, 2'b11);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // All phases one cycle long
      f_req_valid = 1'b1; f_req_write = 1'b1; f_req_addr = 8'h5A; f_req_wdata = 8'h33;
      @(negedge clk);
      check("fast_ready", f_req_ready, 1'b1);
      @(posedge clk);
      #1;
      f_req_valid = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         check("fast_zpvv", f_zpvv_n, (c != 2));
         check("fast_cht", f_chtvv_n, 1'b1);
         check("fast_done", f_rsp_done, (c == 4));
         check("fast_shavv", f_shavv_n, (c <= 3) ? 8'hA5 : 8'hFF);
      end

      // Default-timing write
      do_req(1'b1, 8'h15, 8'hA5, 1'b0, w);
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         check("wr_shavv", shavv_n, (c <= 10) ? 8'hEA : 8'hFF);
         check("wr_zpvv", zpvv_n, !(c >= 3 && c <= 8));
         check("wr_oe", data_oe, (c <= 10));
         check("wr_done", rsp_done, (c == 11));
      end

      // Default-timing read with fixed data_i
      di_force = 1'b1; di_val = 8'h3C;
      @(posedge clk);
      #1;
      do_req(1'b0, 8'h14, 8'h00, 1'b0, w);
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         check("rd_cht", chtvv_n, !(c >= 3 && c <= 8));
         check("rd_zpvv", zpvv_n, 1'b1);
         check("rd_done", rsp_done, (c == 11));
         if (c == 11) check("rd_rdata", rsp_rdata, 8'h3C);
      end
      di_force = 1'b0;

      // Back-to-back writes with req_valid held
      @(posedge clk);
      #1;
      do_req(1'b1, 8'h21, 8'h11, 1'b1, w);
      do_req(1'b1, 8'h22, 8'h22, 1'b0, w);
      check("b2b_accept_wait", w, N + 1);
      repeat (S + 1) @(negedge clk);
      #1;
      check("b2b_strobe_gap", last_gap, S + H + 1);
      repeat (N) @(posedge clk);
      #1;

      // Reset in the third STROBE cycle of a write
      do_req(1'b1, 8'h15, 8'hA5, 1'b0, w);
      repeat (S + 2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      #1;
      check("abort_zpvv", zpvv_n, 1'b1);
      check("abort_shavv", shavv_n, 8'hFF);
      check("abort_oe", data_oe, 1'b0);
      check("abort_ready", req_ready, 1'b1);
      for (int c = 0; c < N + 2; c++) begin
         @(negedge clk);
         #1;
         check("abort_no_done", rsp_done, 1'b0);
      end

      // Random traffic, including data_i changing every cycle and sporadic resets
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk);
         #1;
         req_valid = ($urandom_range(0, 99) < 60);
         req_write = 1'($urandom);
         req_addr  = 8'($urandom);
         req_wdata = 8'($urandom);
         reset     = ($urandom_range(0, 299) == 0);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      req_valid = 1'b0;
      repeat (N + 3) @(posedge clk);
      #1;
      check("sb_drain", sb.size(), 0);
      check("random_activity", (completions > 50), 1'b1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/vvbus_port_master.md
VVBUS_PORT_MASTER -- requirements
Module: vvbus_port_master

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2: cycles the address (and write data) are driven before the strobe falls; legal range 1..15.
REQ-002 SHALL have parameter STROBE_CYC, default 6: cycles the strobe is held low; legal range 1..15.
REQ-003 SHALL have parameter HOLD_CYC, default 2: cycles the address and data are held after the strobe rises; legal range 1..15.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  block can accept a request this cycle.
REQ-008 req_write  in  1  1 = port write, 0 = port read.
REQ-009 req_addr  in  8  port number.
REQ-010 req_wdata  in  8  write data.
REQ-011 rsp_done  out  1  one-cycle pulse marking the end of a bus cycle.
REQ-012 rsp_rdata  out  8  read data, valid when rsp_done is high after a read.
REQ-013 shavv_n  out  8  bus address, active low (~port).
REQ-014 data_o  out  8  bus write data.
REQ-015 data_oe  out  1  bus data driver enable.
REQ-016 data_i  in  8  bus read data.
REQ-017 zpvv_n  out  1  write strobe, active low.
REQ-018 chtvv_n  out  1  read strobe, active low.

Function
REQ-019 SHALL implement the FSM IDLE -> SETUP -> STROBE -> HOLD -> IDLE, with a 4-bit down-counter loaded on each state entry.
REQ-020 req_ready SHALL be 1 exactly when state is IDLE and reset is low; a request is accepted on a clock edge where req_valid and req_ready are both 1.
REQ-021 On acceptance, SHALL latch req_write, req_addr and req_wdata and enter SETUP; request inputs are ignored until the next IDLE.
REQ-022 SETUP SHALL last SETUP_CYC cycles, STROBE SHALL last STROBE_CYC cycles and HOLD SHALL last HOLD_CYC cycles, so a bus cycle occupies SETUP_CYC+STROBE_CYC+HOLD_CYC cycles after the accept edge.
REQ-023 In SETUP, STROBE and HOLD, shavv_n SHALL equal ~latched address; in IDLE it SHALL be 8'hFF.
REQ-024 For writes, data_oe SHALL be 1 and data_o SHALL equal the latched data throughout SETUP, STROBE and HOLD; otherwise data_oe SHALL be 0 and data_o SHALL be 8'hFF.
REQ-025 zpvv_n SHALL be 0 only in STROBE of a write; chtvv_n SHALL be 0 only in STROBE of a read; both strobes SHALL never be low at the same time.
REQ-026 All bus outputs SHALL be registered, with no combinational path from the request inputs to the bus outputs.
REQ-027 For reads, rsp_rdata SHALL capture data_i on the clock edge that ends the last STROBE cycle and SHALL hold that value until the next read completes.
REQ-028 rsp_done SHALL pulse high for exactly one cycle: the first IDLE cycle after HOLD. It pulses for writes as well as reads.
REQ-029 Back-to-back: a request presented during the rsp_done cycle SHALL be accepted in that same cycle, giving zero idle gap beyond that one cycle.
REQ-030 req_valid deasserted while the block is busy SHALL have no effect, and the cycle in flight SHALL complete normally.

Reset
REQ-031 While reset is high, on the next clock edge: state SHALL be IDLE; req_ready SHALL be 0 (1 after reset falls); rsp_done SHALL be 0; rsp_rdata SHALL be 8'hFF; shavv_n SHALL be 8'hFF; data_o SHALL be 8'hFF; data_oe SHALL be 0; zpvv_n and chtvv_n SHALL be 1.
REQ-032 Reset asserted mid-cycle in any state SHALL abort the cycle: strobes high, no rsp_done pulse, and the request is not retried.

Verification
REQ-033 Defaults; write 0x15 <- 0xA5 -> shavv_n=0xEA from cycle 1, zpvv_n low cycles 3..8, data_oe cycles 1..10, rsp_done at cycle 11.
REQ-034 Defaults; read 0x14 with data_i=0x3C during STROBE -> chtvv_n low cycles 3..8, zpvv_n stays 1, rsp_rdata=0x3C when rsp_done pulses.
REQ-035 req_valid held high with two queued writes -> second accepted in the rsp_done cycle of the first; strobe pulses separated by exactly SETUP_CYC+HOLD_CYC+1 cycles.
REQ-036 Reset asserted during the 3rd STROBE cycle of a write -> zpvv_n=1, shavv_n=0xFF, data_oe=0 next edge; no rsp_done; req_ready=1 after release.
REQ-037 SETUP_CYC=STROBE_CYC=HOLD_CYC=1 -> strobe low exactly 1 cycle; rsp_done at cycle 4 after accept.
REQ-038 data_i changing every cycle during read -> rsp_rdata equals the value present in the last STROBE cycle only.
